// File: rtl/cache_ctrl_if.sv
// Bundle of the CPU request/response, data-array and main-memory line ports of cache_ctrl.
// master = the cache controller, slave = everything around it (CPU, data array, memory).
interface cache_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 128,
   parameter int IDX_W  = 4
);
   logic              cpu_req_valid;
   logic              cpu_req_rw;
   logic [ADDR_W-1:0] cpu_req_addr;
   logic [31:0]       cpu_req_data;
   logic              cpu_res_ready;
   logic [31:0]       cpu_res_data;

   logic [IDX_W-1:0]  data_req_index;
   logic              data_req_we;
   logic [LINE_W-1:0] data_write;
   logic [LINE_W-1:0] data_read;

   logic              mem_req_valid;
   logic              mem_req_rw;
   logic [ADDR_W-1:0] mem_req_addr;
   logic [LINE_W-1:0] mem_req_data;
   logic              mem_data_ready;
   logic [LINE_W-1:0] mem_data;

   modport master (
      input  cpu_req_valid, cpu_req_rw, cpu_req_addr, cpu_req_data,
      output cpu_res_ready, cpu_res_data,
      output data_req_index, data_req_we, data_write,
      input  data_read,
      output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data,
      input  mem_data_ready, mem_data
   );

   modport slave (
      output cpu_req_valid, cpu_req_rw, cpu_req_addr, cpu_req_data,
      input  cpu_res_ready, cpu_res_data,
      input  data_req_index, data_req_we, data_write,
      output data_read,
      input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data,
      output mem_data_ready, mem_data
   );
endinterface

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller. Tag/valid/dirty live here;
// the line data lives in an external array driven through the bus interface.
module cache_ctrl #(
   parameter int LINES  = 16,
   parameter int ADDR_W = 32,
   parameter int LINE_W = 128
) (
   input  logic         clk,
   input  logic         reset,
   cache_ctrl_if.master bus
);
   localparam int IDX_W  = $clog2(LINES);
   localparam int OFF_W  = $clog2(LINE_W / 8);
   localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
   localparam int WORDS  = LINE_W / 32;
   localparam int WSEL_W = $clog2(WORDS);

   typedef enum logic [1:0] {IDLE, COMPARE, WRITE_BACK, ALLOCATE} state_t;

   state_t            state, state_nx;
   logic              req_rw;
   logic [TAG_W-1:0]  req_tag;
   logic [IDX_W-1:0]  req_idx;
   logic [WSEL_W-1:0] req_word;
   logic [31:0]       req_data;

   logic [LINES-1:0]  valid_q, dirty_q;
   logic [TAG_W-1:0]  tag_q [LINES];
   logic              alloc_gap;
   logic              hit, set_dirty, do_fill;

   assign hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_nx           = state;
      set_dirty          = 1'b0;
      do_fill            = 1'b0;
      bus.cpu_res_ready  = 1'b0;
      bus.cpu_res_data   = '0;
      bus.data_req_we    = 1'b0;
      bus.data_write     = '0;
      bus.mem_req_valid  = 1'b0;
      bus.mem_req_rw     = 1'b0;
      bus.mem_req_addr   = '0;
      bus.mem_req_data   = '0;
      bus.data_req_index = (state == IDLE) ? bus.cpu_req_addr[OFF_W +: IDX_W] : req_idx;

      case (state)
         IDLE: begin
            if (bus.cpu_req_valid) state_nx = COMPARE;
         end
         COMPARE: begin
            if (hit) begin
               bus.cpu_res_ready = 1'b1;
               bus.cpu_res_data  = bus.data_read[int'(req_word)*32 +: 32];
               if (req_rw) begin
                  bus.data_req_we                         = 1'b1;
                  bus.data_write                          = bus.data_read;
                  bus.data_write[int'(req_word)*32 +: 32] = req_data;
                  set_dirty                               = 1'b1;
               end
               state_nx = IDLE;
            end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
               state_nx = WRITE_BACK;
            end else begin
               state_nx = ALLOCATE;
            end
         end
         WRITE_BACK: begin
            bus.mem_req_valid = 1'b1;
            bus.mem_req_rw    = 1'b1;
            bus.mem_req_addr  = {tag_q[req_idx], req_idx, {OFF_W{1'b0}}};
            bus.mem_req_data  = bus.data_read;
            if (bus.mem_data_ready) state_nx = ALLOCATE;
         end
         ALLOCATE: begin
            // First cycle after a write-back keeps valid low so memory sees a fresh request.
            if (!alloc_gap) begin
               bus.mem_req_valid = 1'b1;
               bus.mem_req_addr  = {req_tag, req_idx, {OFF_W{1'b0}}};
               if (bus.mem_data_ready) begin
                  bus.data_req_we = 1'b1;
                  bus.data_write  = bus.mem_data;
                  do_fill         = 1'b1;
                  state_nx        = COMPARE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         req_rw    <= 1'b0;
         req_tag   <= '0;
         req_idx   <= '0;
         req_word  <= '0;
         req_data  <= '0;
         valid_q   <= '0;
         dirty_q   <= '0;
         alloc_gap <= 1'b0;
      end else begin
         state     <= state_nx;
         alloc_gap <= (state == WRITE_BACK) && bus.mem_data_ready;
         if (state == IDLE && bus.cpu_req_valid) begin
            req_rw   <= bus.cpu_req_rw;
            req_tag  <= bus.cpu_req_addr[ADDR_W-1 -: TAG_W];
            req_idx  <= bus.cpu_req_addr[OFF_W +: IDX_W];
            req_word <= bus.cpu_req_addr[OFF_W-1 -: WSEL_W];
            req_data <= bus.cpu_req_data;
         end
         if (set_dirty) dirty_q[req_idx] <= 1'b1;
         if (do_fill) begin
            valid_q[req_idx] <= 1'b1;
            dirty_q[req_idx] <= 1'b0;
         end
      end
   end

   // NOTE: the tag array is not reset; a cleared valid bit makes its stale contents irrelevant.
   always_ff @(posedge clk) begin
      if (do_fill) tag_q[req_idx] <= req_tag;
   end
endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: directed scenarios then random traffic against a
// word-level golden memory and a line-residency model.
module tb_cache_ctrl;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   cache_ctrl_if bus ();
   cache_ctrl dut (.clk(clk), .reset(reset), .bus(bus.master));

   // External data array with combinational read.
   logic [127:0] darr [16];
   assign bus.data_read = darr[bus.data_req_index];
   always @(posedge clk) if (bus.data_req_we) darr[bus.data_req_index] <= bus.data_write;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Main memory (word-addressed) and the golden CPU-visible memory.
   logic [31:0] mem_w [int unsigned];
   logic [31:0] gold  [int unsigned];

   function automatic logic [31:0] init_word(int unsigned k);
      return (k * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction
   function automatic logic [31:0] mem_rd(int unsigned k);
      return mem_w.exists(k) ? mem_w[k] : init_word(k);
   endfunction
   function automatic logic [31:0] gold_rd(int unsigned k);
      return gold.exists(k) ? gold[k] : init_word(k);
   endfunction
   function automatic logic [127:0] mem_line(logic [31:0] la);
      logic [127:0] l;
      for (int i = 0; i < 4; i++) l[i*32 +: 32] = mem_rd(int'(la >> 2) + i);
      return l;
   endfunction
   function automatic logic [127:0] gold_line(logic [31:0] la);
      logic [127:0] l;
      for (int i = 0; i < 4; i++) l[i*32 +: 32] = gold_rd(int'(la >> 2) + i);
      return l;
   endfunction

   // Which line each index holds, and whether it differs from memory.
   logic        m_valid [16];
   logic        m_dirty [16];
   logic [23:0] m_tag   [16];

   task automatic model_clear();
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
         m_tag[i]   = '0;
      end
   endtask

   // Memory responder: answers each request after mem_delay waiting cycles.
   int          mem_delay = 0;
   int          wait_cnt  = 0;
   logic [31:0] rq_addr [$];
   logic        rq_rw   [$];

   initial begin
      bus.mem_data_ready = 1'b0;
      bus.mem_data       = '0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            bus.mem_data_ready = 1'b0;
            wait_cnt           = 0;
         end else if (bus.mem_data_ready) begin
            bus.mem_data_ready = 1'b0;
         end else if (bus.mem_req_valid) begin
            if (wait_cnt < mem_delay) begin
               wait_cnt++;
            end else begin
               wait_cnt = 0;
               rq_addr.push_back(bus.mem_req_addr);
               rq_rw.push_back(bus.mem_req_rw);
               if (bus.mem_req_rw) begin
                  check("wb_data", bus.mem_req_data, gold_line(bus.mem_req_addr));
                  for (int i = 0; i < 4; i++)
                     mem_w[int'(bus.mem_req_addr >> 2) + i] = bus.mem_req_data[i*32 +: 32];
               end else begin
                  bus.mem_data = mem_line(bus.mem_req_addr);
               end
               bus.mem_data_ready = 1'b1;
            end
         end
      end
   end

   logic [31:0] last_rdata;
   int          last_nreq;

   task automatic access(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                         input int delay, input bit spam);
      logic [3:0]  idx;
      logic [23:0] tg;
      bit          hit, wb, done;
      int          lat, q0, exp_lat, exp_n, fi;
      logic [31:0] rdata;
      idx   = addr[7:4];
      tg    = addr[31:8];
      hit   = m_valid[idx] && (m_tag[idx] == tg);
      wb    = !hit && m_valid[idx] && m_dirty[idx];
      mem_delay = delay;
      q0    = rq_addr.size();
      done  = 1'b0;
      rdata = '0;
      @(posedge clk); #1;
      bus.cpu_req_valid = 1'b1;
      bus.cpu_req_rw    = rw;
      bus.cpu_req_addr  = addr;
      bus.cpu_req_data  = wdata;
      @(posedge clk); #1;
      lat = 1;
      if (spam) begin
         bus.cpu_req_rw   = 1'b1;
         bus.cpu_req_addr = 32'h0000_3304;
         bus.cpu_req_data = 32'hDEAD_BEEF;
      end else begin
         bus.cpu_req_valid = 1'b0;
      end
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk);
         lat++;
         if (bus.cpu_res_ready) begin
            done              = 1'b1;
            rdata             = bus.cpu_res_data;
            bus.cpu_req_valid = 1'b0;
         end else if (spam && bus.mem_req_valid) begin
            check("alloc_addr_hold", bus.mem_req_addr, {addr[31:4], 4'h0});
         end
      end
      bus.cpu_req_valid = 1'b0;
      check("resp_seen", done, 1'b1);
      exp_lat   = hit ? 2 : (wb ? 6 + 2*delay : 4 + delay);
      exp_n     = hit ? 0 : (wb ? 2 : 1);
      last_nreq = rq_addr.size() - q0;
      check("latency", lat, exp_lat);
      check("mem_req_count", last_nreq, exp_n);
      if (!hit && last_nreq == exp_n) begin
         if (wb) begin
            check("wb_addr", rq_addr[q0], {m_tag[idx], idx, 4'h0});
            check("wb_rw", rq_rw[q0], 1'b1);
         end
         fi = wb ? q0 + 1 : q0;
         check("fill_addr", rq_addr[fi], {addr[31:4], 4'h0});
         check("fill_rw", rq_rw[fi], 1'b0);
      end
      if (rw) gold[int'(addr >> 2)] = wdata;
      else    check("rdata", rdata, gold_rd(int'(addr >> 2)));
      last_rdata   = rdata;
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_dirty[idx] = hit ? (m_dirty[idx] | rw) : rw;
   endtask

   initial begin
      reset             = 1'b0;
      bus.cpu_req_valid = 1'b0;
      bus.cpu_req_rw    = 1'b0;
      bus.cpu_req_addr  = '0;
      bus.cpu_req_data  = '0;
      for (int i = 0; i < 16; i++) darr[i] = '0;
      model_clear();

      repeat (3) @(negedge clk);
      check("rst_mem_valid", bus.mem_req_valid, 1'b0);
      check("rst_res_ready", bus.cpu_res_ready, 1'b0);
      check("rst_data_we", bus.data_req_we, 1'b0);
      check("rst_res_data", bus.cpu_res_data, 32'h0);
      reset = 1'b1;

      // Cold read of a preloaded line.
      mem_w[32'h100 >> 2] = 32'h0000_AAAA;
      mem_w[32'h104 >> 2] = 32'h0000_BBBB;
      mem_w[32'h108 >> 2] = 32'h0000_CCCC;
      mem_w[32'h10C >> 2] = 32'h0000_DDDD;
      gold = mem_w;
      access(1'b0, 32'h0000_0104, 32'h0, 0, 1'b0);
      check("s1_word1", last_rdata, 32'h0000_BBBB);

      access(1'b0, 32'h0000_0104, 32'h0, 0, 1'b0);
      check("s2_hit_no_mem", last_nreq, 0);

      access(1'b1, 32'h0000_0108, 32'h1234_5678, 0, 1'b0);
      @(posedge clk); #1;
      check("s3_array_word2", darr[0][95:64], 32'h1234_5678);

      // Conflict on index 0 with the dirty line forces a write-back first.
      access(1'b0, 32'h0000_1100, 32'h0, 1, 1'b0);

      // Long fill wait with CPU requests presented meanwhile.
      access(1'b0, 32'h0000_2204, 32'h0, 10, 1'b1);

      // Reset while a fill is outstanding.
      mem_delay = 10;
      @(posedge clk); #1;
      bus.cpu_req_valid = 1'b1;
      bus.cpu_req_rw    = 1'b0;
      bus.cpu_req_addr  = 32'h0000_0504;
      @(posedge clk); #1;
      bus.cpu_req_valid = 1'b0;
      repeat (4) @(negedge clk);
      #2;
      check("s6_in_alloc", bus.mem_req_valid, 1'b1);
      reset = 1'b0;
      #1;
      check("s6_mem_valid", bus.mem_req_valid, 1'b0);
      check("s6_mem_addr", bus.mem_req_addr, 32'h0);
      check("s6_res_ready", bus.cpu_res_ready, 1'b0);
      check("s6_data_we", bus.data_req_we, 1'b0);
      @(negedge clk); #2;
      reset = 1'b1;
      model_clear();
      gold = mem_w;
      access(1'b0, 32'h0000_0104, 32'h0, 1, 1'b0);
      check("s6_reread_miss", last_nreq, 1);

      // Random traffic over a few tags on a few indices to force conflicts.
      for (int n = 0; n < 250; n++) begin
         logic [31:0] a;
         a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2);
         access(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3), 1'b0);
      end

      // Requests offered while busy must not have been taken.
      access(1'b0, 32'h0000_3304, 32'h0, 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
